// File: rtl/arm_dec_pkg.sv
// -----------------------------------------------------------------------------
// arm_dec_pkg
// Shared constants and types for the registered ARM main decoder.
//   OP_*         : instr[27:26] major opcode classes
//   IMMSRC_*     : ImmSrc encodings (imm8 / imm12 / imm24)
//   REGSRC_*     : RegSrc encodings used by the decoder
//   SH_ROR       : shiftControl value for rotate-right (DP immediates)
//   BX_PATTERN   : instr[27:4] value identifying BX
//   seq_state_t  : sequencer state (IDLE / SEQ / WB)
//   ctrl_t       : single-op control bundle produced by main_decode_comb
// -----------------------------------------------------------------------------
package arm_dec_pkg;

    localparam logic [1:0] OP_DP   = 2'b00;
    localparam logic [1:0] OP_MEM  = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    localparam logic [1:0] IMMSRC_IMM8  = 2'b00;
    localparam logic [1:0] IMMSRC_IMM12 = 2'b01;
    localparam logic [1:0] IMMSRC_IMM24 = 2'b10;

    localparam logic [2:0] REGSRC_DP  = 3'b000;
    localparam logic [2:0] REGSRC_B   = 3'b001;
    localparam logic [2:0] REGSRC_STR = 3'b010;
    localparam logic [2:0] REGSRC_BL  = 3'b101;

    localparam logic [1:0]  SH_ROR     = 2'b11;
    localparam logic [23:0] BX_PATTERN = 24'h12FFF1;

    // IDLE: nothing left to emit beyond the bundle in the output register.
    // SEQ : more LDR/STR micro-ops remain.  WB: only the base writeback remains.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEQ  = 2'b01,
        ST_WB   = 2'b10
    } seq_state_t;

    typedef struct packed {
        logic       reg_w;
        logic       mem_to_reg;
        logic       alu_src;
        logic       write_src;
        logic       alu_op;
        logic       branch;
        logic       mem_w;
        logic [1:0] imm_src;
        logic [2:0] reg_src;
        logic [4:0] shamt;
        logic [1:0] sh_ctrl;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // Controls of a single LDR (is_load=1) or STR (is_load=0) micro-op.
    function automatic ctrl_t mem_uop_ctrl(input logic is_load);
        ctrl_t c;
        c         = CTRL_NOP;
        c.alu_src = 1'b1;
        c.imm_src = IMMSRC_IMM12;
        if (is_load) begin
            c.reg_w      = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_src    = REGSRC_DP;
        end else begin
            c.mem_w   = 1'b1;
            c.reg_src = REGSRC_STR;
        end
        return c;
    endfunction

endpackage

// File: rtl/main_decode_comb.sv
// -----------------------------------------------------------------------------
// main_decode_comb
// Combinational single-op main decode: DP, BX, LDR/STR, B/BL.  Op=11 and
// block transfers (Op=10, I=0) produce an all-zero NOP bundle here; the
// sequencer in main_decoder_seq builds block-transfer micro-ops itself.
// Ports:
//   i_instr : ARM instruction word
//   o_ctrl  : decoded control bundle
// -----------------------------------------------------------------------------
module main_decode_comb
    import arm_dec_pkg::*;
(
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl
);

    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_unused_bits;

    assign w_op          = i_instr[27:26];
    assign w_funct       = i_instr[25:20];
    assign w_unused_bits = ^{i_instr[31:28], i_instr[3:0]};

    always_comb begin
        o_ctrl = CTRL_NOP;
        if (i_instr[27:4] == BX_PATTERN) begin
            o_ctrl.reg_src = REGSRC_B;
        end else begin
            case (w_op)
                OP_DP: begin
                    o_ctrl.alu_op  = 1'b1;
                    o_ctrl.reg_src = REGSRC_DP;
                    // CMP (opcode 1010) only sets flags
                    o_ctrl.reg_w   = ~(w_funct[4:1] == 4'b1010);
                    if (w_funct[5]) begin
                        o_ctrl.alu_src = 1'b1;
                        o_ctrl.imm_src = IMMSRC_IMM8;
                        o_ctrl.shamt   = {i_instr[11:8], 1'b0};
                        o_ctrl.sh_ctrl = SH_ROR;
                    end else begin
                        o_ctrl.shamt   = i_instr[11:7];
                        o_ctrl.sh_ctrl = i_instr[6:5];
                    end
                end
                OP_MEM: begin
                    o_ctrl = mem_uop_ctrl(w_funct[0]);
                end
                OP_BR: begin
                    if (w_funct[5]) begin
                        o_ctrl.branch  = 1'b1;
                        o_ctrl.alu_src = 1'b1;
                        o_ctrl.imm_src = IMMSRC_IMM24;
                        if (w_funct[4]) begin
                            o_ctrl.reg_w     = 1'b1;
                            o_ctrl.write_src = 1'b1;
                            o_ctrl.reg_src   = REGSRC_BL;
                        end else begin
                            o_ctrl.reg_src = REGSRC_B;
                        end
                    end
                end
                OP_NONE: o_ctrl = CTRL_NOP;
                default: o_ctrl = CTRL_NOP;
            endcase
        end
    end

endmodule

// File: rtl/main_decoder_seq.sv
// -----------------------------------------------------------------------------
// main_decoder_seq
// Registered main decoder with LDM/STM (increment-after) sequencing.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   flush                 : drop output bundle and any sequence in progress
//   in_valid/in_ready     : instruction handshake from decode
//   instr                 : ARM instruction word
//   out_valid/out_ready   : control-bundle handshake to execute
//   RegW..MemW, ImmSrc, RegSrc, shamt, shiftControl : main-decoder controls
//   out_cond              : condition field, repeated on every micro-op
//   uop_override/rd/rn/offset/force_add/last : micro-op side-band fields
//   o_dbg_state           : current sequencer state (seq_state_t encoding)
//
// Handshake: a word moves when valid & ready are both high at a rising edge.
// The output register never changes while out_valid & ~out_ready, and
// out_valid never drops without a transfer (flush and reset excepted).
// in_ready does not depend on in_valid.
// -----------------------------------------------------------------------------
module main_decoder_seq
    import arm_dec_pkg::*;
#(
    parameter int  NREG     = 16,
    parameter int  OFF_W    = 12,
    parameter bit  BLOCK_EN = 1'b1,
    localparam int REG_W    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             RegW,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             WriteSrc,
    output logic             ALUOp,
    output logic             Branch,
    output logic             MemW,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       RegSrc,
    output logic [4:0]       shamt,
    output logic [1:0]       shiftControl,
    output logic [3:0]       out_cond,
    output logic             uop_override,
    output logic [REG_W-1:0] uop_rd,
    output logic [REG_W-1:0] uop_rn,
    output logic [OFF_W-1:0] uop_offset,
    output logic             uop_force_add,
    output logic             uop_last,
    output logic [1:0]       o_dbg_state
);

    localparam int CNT_W = REG_W + 1;

    // Registered state
    seq_state_t       r_state;
    logic             r_valid;
    ctrl_t            r_ctrl;
    logic [3:0]       r_cond;
    logic             r_override;
    logic [REG_W-1:0] r_rd;
    logic [REG_W-1:0] r_rn;
    logic [OFF_W-1:0] r_offset;
    logic             r_force_add;
    logic             r_last;
    logic [NREG-1:0]  r_list;      // registers still to emit
    logic [CNT_W-1:0] r_k;         // micro-ops already emitted
    logic             r_l;
    logic [REG_W-1:0] r_base;
    logic [OFF_W-1:0] r_wb_off;
    logic             r_do_wb;

    // Next-state values
    seq_state_t       n_state;
    logic             n_valid;
    ctrl_t            n_ctrl;
    logic [3:0]       n_cond;
    logic             n_override;
    logic [REG_W-1:0] n_rd;
    logic [REG_W-1:0] n_rn;
    logic [OFF_W-1:0] n_offset;
    logic             n_force_add;
    logic             n_last;
    logic [NREG-1:0]  n_list;
    logic [CNT_W-1:0] n_k;
    logic             n_l;
    logic [REG_W-1:0] n_base;
    logic [OFF_W-1:0] n_wb_off;
    logic             n_do_wb;

    // Combinational helpers
    ctrl_t            w_dec;
    logic             w_accept;
    logic             w_out_xfer;
    logic [NREG-1:0]  w_in_list;
    logic [NREG-1:0]  w_src_list;
    logic [NREG-1:0]  w_rest;
    logic [REG_W-1:0] w_idx;
    logic [CNT_W-1:0] w_pop;
    logic             w_is_block;
    logic             w_in_l;
    logic [REG_W-1:0] w_in_rn;
    logic             w_in_do_wb;
    logic             w_unused_instr;

    main_decode_comb u_dec (
        .i_instr (instr),
        .o_ctrl  (w_dec)
    );

    assign in_ready   = (r_state == ST_IDLE) && (!r_valid || out_ready) && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_out_xfer = r_valid && out_ready;

    assign w_in_list  = instr[NREG-1:0];
    assign w_in_l     = instr[20];
    assign w_in_rn    = REG_W'(instr[19:16]);
    assign w_is_block = BLOCK_EN && (instr[27:26] == OP_BR) && !instr[25] && (w_in_list != '0);
    // A load that reloads the base keeps the loaded value: no writeback.
    assign w_in_do_wb = instr[21] && !(w_in_l && w_in_list[w_in_rn]);
    assign w_unused_instr = ^instr;

    // Lowest set bit of the list being worked on (new list when idle,
    // remaining list otherwise), the list with that bit cleared, and its
    // population count (only meaningful on acceptance).
    always_comb begin
        w_src_list = (r_state == ST_IDLE) ? w_in_list : r_list;
        w_rest     = w_src_list & (w_src_list - NREG'(1));
        w_idx      = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (w_src_list[i]) w_idx = REG_W'(i);
        end
        w_pop = '0;
        for (int i = 0; i < NREG; i++) begin
            w_pop = w_pop + CNT_W'(w_src_list[i]);
        end
    end

    always_comb begin
        n_state     = r_state;
        n_valid     = r_valid;
        n_ctrl      = r_ctrl;
        n_cond      = r_cond;
        n_override  = r_override;
        n_rd        = r_rd;
        n_rn        = r_rn;
        n_offset    = r_offset;
        n_force_add = r_force_add;
        n_last      = r_last;
        n_list      = r_list;
        n_k         = r_k;
        n_l         = r_l;
        n_base      = r_base;
        n_wb_off    = r_wb_off;
        n_do_wb     = r_do_wb;

        if (flush) begin
            n_state     = ST_IDLE;
            n_valid     = 1'b0;
            n_ctrl      = CTRL_NOP;
            n_cond      = '0;
            n_override  = 1'b0;
            n_rd        = '0;
            n_rn        = '0;
            n_offset    = '0;
            n_force_add = 1'b0;
            n_last      = 1'b1;
            n_list      = '0;
            n_k         = '0;
            n_l         = 1'b0;
            n_base      = '0;
            n_wb_off    = '0;
            n_do_wb     = 1'b0;
        end else if (w_accept) begin
            n_valid = 1'b1;
            n_cond  = instr[31:28];   // held for every micro-op of this instr
            if (w_is_block) begin
                n_l         = w_in_l;
                n_base      = w_in_rn;
                n_do_wb     = w_in_do_wb;
                n_wb_off    = OFF_W'({w_pop, 2'b00});
                n_ctrl      = mem_uop_ctrl(w_in_l);
                n_override  = 1'b1;
                n_rd        = w_idx;
                n_rn        = w_in_rn;
                n_offset    = '0;
                n_force_add = 1'b0;
                n_list      = w_rest;
                n_k         = CNT_W'(1);
                if (w_rest == '0) begin
                    n_state = w_in_do_wb ? ST_WB : ST_IDLE;
                    n_last  = !w_in_do_wb;
                end else begin
                    n_state = ST_SEQ;
                    n_last  = 1'b0;
                end
            end else begin
                n_state     = ST_IDLE;
                n_ctrl      = w_dec;
                n_override  = 1'b0;
                n_rd        = '0;
                n_rn        = '0;
                n_offset    = '0;
                n_force_add = 1'b0;
                n_last      = 1'b1;
                n_list      = '0;
                n_k         = '0;
            end
        end else if (w_out_xfer) begin
            case (r_state)
                ST_SEQ: begin
                    n_ctrl      = mem_uop_ctrl(r_l);
                    n_override  = 1'b1;
                    n_rd        = w_idx;
                    n_rn        = r_base;
                    n_offset    = OFF_W'({r_k, 2'b00});
                    n_force_add = 1'b0;
                    n_k         = r_k + CNT_W'(1);
                    n_list      = w_rest;
                    if (w_rest == '0) begin
                        n_state = r_do_wb ? ST_WB : ST_IDLE;
                        n_last  = !r_do_wb;
                    end else begin
                        n_last  = 1'b0;
                    end
                end
                ST_WB: begin
                    n_ctrl         = CTRL_NOP;
                    n_ctrl.reg_w   = 1'b1;
                    n_ctrl.alu_src = 1'b1;
                    n_ctrl.alu_op  = 1'b1;
                    n_override     = 1'b1;
                    n_rd           = r_base;
                    n_rn           = r_base;
                    n_offset       = r_wb_off;
                    n_force_add    = 1'b1;
                    n_last         = 1'b1;
                    n_state        = ST_IDLE;
                    n_list         = '0;
                    n_k            = '0;
                end
                default: n_valid = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_valid     <= 1'b0;
            r_ctrl      <= CTRL_NOP;
            r_cond      <= '0;
            r_override  <= 1'b0;
            r_rd        <= '0;
            r_rn        <= '0;
            r_offset    <= '0;
            r_force_add <= 1'b0;
            r_last      <= 1'b1;
            r_list      <= '0;
            r_k         <= '0;
            r_l         <= 1'b0;
            r_base      <= '0;
            r_wb_off    <= '0;
            r_do_wb     <= 1'b0;
        end else begin
            r_state     <= n_state;
            r_valid     <= n_valid;
            r_ctrl      <= n_ctrl;
            r_cond      <= n_cond;
            r_override  <= n_override;
            r_rd        <= n_rd;
            r_rn        <= n_rn;
            r_offset    <= n_offset;
            r_force_add <= n_force_add;
            r_last      <= n_last;
            r_list      <= n_list;
            r_k         <= n_k;
            r_l         <= n_l;
            r_base      <= n_base;
            r_wb_off    <= n_wb_off;
            r_do_wb     <= n_do_wb;
        end
    end

    assign out_valid     = r_valid;
    assign RegW          = r_ctrl.reg_w;
    assign MemtoReg      = r_ctrl.mem_to_reg;
    assign ALUSrc        = r_ctrl.alu_src;
    assign WriteSrc      = r_ctrl.write_src;
    assign ALUOp         = r_ctrl.alu_op;
    assign Branch        = r_ctrl.branch;
    assign MemW          = r_ctrl.mem_w;
    assign ImmSrc        = r_ctrl.imm_src;
    assign RegSrc        = r_ctrl.reg_src;
    assign shamt         = r_ctrl.shamt;
    assign shiftControl  = r_ctrl.sh_ctrl;
    assign out_cond      = r_cond;
    assign uop_override  = r_override;
    assign uop_rd        = r_rd;
    assign uop_rn        = r_rn;
    assign uop_offset    = r_offset;
    assign uop_force_add = r_force_add;
    assign uop_last      = r_last;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_main_decoder_seq.sv
// -----------------------------------------------------------------------------
// tb_main_decoder_seq
// Bench for main_decoder_seq (NREG=16, OFF_W=12, BLOCK_EN=1).  Expected
// bundles come from a per-instruction model that expands each accepted
// instruction into its full list of bundles in exp_q.
// -----------------------------------------------------------------------------
module tb_main_decoder_seq;

  localparam int BW = 46;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic        RegW, MemtoReg, ALUSrc, WriteSrc, ALUOp, Branch, MemW;
  logic [1:0]  ImmSrc, shiftControl, o_dbg_state;
  logic [2:0]  RegSrc;
  logic [4:0]  shamt;
  logic [3:0]  out_cond, uop_rd, uop_rn;
  logic        uop_override, uop_force_add, uop_last;
  logic [11:0] uop_offset;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;            // 0: out_ready driven by directed steps, 1: random
  logic [BW-1:0] exp_q[$];

  main_decoder_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .RegW(RegW), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .WriteSrc(WriteSrc),
    .ALUOp(ALUOp), .Branch(Branch), .MemW(MemW), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .shamt(shamt), .shiftControl(shiftControl),
    .out_cond(out_cond), .uop_override(uop_override), .uop_rd(uop_rd),
    .uop_rn(uop_rn), .uop_offset(uop_offset), .uop_force_add(uop_force_add),
    .uop_last(uop_last), .o_dbg_state(o_dbg_state)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] pack_out();
    return {RegW, MemtoReg, ALUSrc, WriteSrc, ALUOp, Branch, MemW, ImmSrc, RegSrc,
            shamt, shiftControl, out_cond, uop_override, uop_rd, uop_rn, uop_offset,
            uop_force_add, uop_last};
  endfunction

  // flags = {RegW, MemtoReg, ALUSrc, WriteSrc, ALUOp, Branch, MemW}
  function automatic logic [BW-1:0] mk(input logic [6:0] flags, input logic [1:0] imm,
      input logic [2:0] rsrc, input logic [4:0] sa, input logic [1:0] sh, input logic [3:0] cond,
      input logic ovr, input logic [3:0] rd, input logic [3:0] rn, input logic [11:0] off,
      input logic fadd, input logic last);
    return {flags, imm, rsrc, sa, sh, cond, ovr, rd, rn, off, fadd, last};
  endfunction

  // Reference model: expand one accepted instruction into all of its bundles.
  task automatic model_push(input logic [31:0] ins);
    logic [3:0]  cond;
    logic [15:0] lst;
    logic [3:0]  rn;
    logic        l, w, rw;
    logic [BW-1:0] b;
    int n;
    cond = ins[31:28];
    if (ins[27:25] == 3'b100) begin
      lst = ins[15:0]; rn = ins[19:16]; l = ins[20]; w = ins[21];
      if (lst == 16'h0) begin
        exp_q.push_back(mk(7'b0, 2'b00, 3'b000, 5'd0, 2'b00, cond, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1));
      end else begin
        n = 0;
        for (int r = 0; r < 16; r++) begin
          if (lst[r]) begin
            if (l) b = mk(7'b1110000, 2'b01, 3'b000, 5'd0, 2'b00, cond, 1'b1, 4'(r), rn, 12'(4 * n), 1'b0, 1'b0);
            else   b = mk(7'b0010001, 2'b01, 3'b010, 5'd0, 2'b00, cond, 1'b1, 4'(r), rn, 12'(4 * n), 1'b0, 1'b0);
            exp_q.push_back(b);
            n++;
          end
        end
        if (w && !(l && lst[rn])) begin
          exp_q.push_back(mk(7'b1010100, 2'b00, 3'b000, 5'd0, 2'b00, cond, 1'b1, rn, rn, 12'(4 * n), 1'b1, 1'b1));
        end else begin
          b = exp_q.pop_back();
          b[0] = 1'b1;
          exp_q.push_back(b);
        end
      end
    end else if (ins[27:4] == 24'h12FFF1) begin
      exp_q.push_back(mk(7'b0, 2'b00, 3'b001, 5'd0, 2'b00, cond, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1));
    end else begin
      case (ins[27:26])
        2'b00: begin
          rw = (ins[24:21] != 4'b1010);
          if (ins[25]) b = mk({rw, 6'b010100}, 2'b00, 3'b000, {ins[11:8], 1'b0}, 2'b11, cond, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1);
          else         b = mk({rw, 6'b000100}, 2'b00, 3'b000, ins[11:7], ins[6:5], cond, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1);
        end
        2'b01: begin
          if (ins[20]) b = mk(7'b1110000, 2'b01, 3'b000, 5'd0, 2'b00, cond, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1);
          else         b = mk(7'b0010001, 2'b01, 3'b010, 5'd0, 2'b00, cond, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1);
        end
        2'b10: begin
          if (ins[24]) b = mk(7'b1011010, 2'b10, 3'b101, 5'd0, 2'b00, cond, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1);
          else         b = mk(7'b0010010, 2'b10, 3'b001, 5'd0, 2'b00, cond, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1);
        end
        default: b = mk(7'b0, 2'b00, 3'b000, 5'd0, 2'b00, cond, 1'b0, 4'd0, 4'd0, 12'd0, 1'b0, 1'b1);
      endcase
      exp_q.push_back(b);
    end
  endtask

  // Scoreboard: checks handshake outputs and the displayed bundle every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_bundle", pack_out(), 46'h1);
      chk("rst_state", o_dbg_state, 2'b00);
    end else begin
      chk("in_ready", in_ready,
          !flush && (exp_q.size() == 0 || (exp_q.size() == 1 && out_ready)));
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("bundle", pack_out(), exp_q[0]);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) model_push(instr);
      end
    end
  end

  // out_ready driver for random mode
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks (called at posedge+1)
  task automatic send(input logic [31:0] ins);
    int t;
    t = 0;
    in_valid = 1'b1;
    instr = ins;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    instr = $urandom;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", exp_q.size() == 0, 1'b1);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [15:0] lst;
    int kind;
    r = $urandom;
    kind = $urandom_range(0, 7);
    case (kind)
      0, 1: r[27:26] = 2'b00;
      2: r[27:26] = 2'b01;
      3: r[27:25] = 3'b101;
      4: r[27:4] = 24'h12FFF1;
      5, 6: begin
        r[27:25] = 3'b100;
        lst = 16'($urandom) & 16'($urandom);
        if ($urandom_range(0, 7) == 0) lst = 16'h0;
        r[15:0] = lst;
      end
      default: r[27:26] = 2'b11;
    endcase
    return r;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] dir_tab[10];

  initial begin
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0;
    dir_tab[0] = 32'hE0821003;  // ADD R1,R2,R3
    dir_tab[1] = 32'hE35102FF;  // CMP R1,#0xFF ror 4
    dir_tab[2] = 32'hE8B0002A;  // LDMIA R0!,{R1,R3,R5}
    dir_tab[3] = 32'hE8B10006;  // LDMIA R1!,{R1,R2}: base loaded, no writeback
    dir_tab[4] = 32'hE8A00003;  // STMIA R0!,{R0,R1}: writeback
    dir_tab[5] = 32'hE8B00000;  // empty list
    dir_tab[6] = 32'hEB000010;  // BL
    dir_tab[7] = 32'hEA000004;  // B
    dir_tab[8] = 32'hE5912004;  // LDR
    dir_tab[9] = 32'hEF000000;  // Op=11

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_uop_last", uop_last, 1'b1);
    @(posedge clk); #1;

    // directed table, execute always ready
    for (int i = 0; i < 10; i++) send(dir_tab[i]);
    drain();

    // STMIA R2,{R4,R7} with execute stalled for two cycles
    send(32'hE8820090);
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // flush during the second LDM micro-op
    send(32'hE8B0002A);
    @(posedge clk); #1;
    out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    send(32'hEB000010);
    drain();

    // reset in the middle of a sequence
    send(32'hE8B0002A);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_state", o_dbg_state, 2'b00);
    chk("midrst_bundle", pack_out(), 46'h1);
    @(posedge clk); #1;
    send(32'hE12FFF1E);         // BX R14
    drain();

    // random instructions with random execute back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(gen_instr());
    end
    drain();
    rdy_mode = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
